// File: rtl/gsim_solver_param.sv
// Gauss-Seidel solver: sweeps each N x N system A*x=b in place and writes x out per matrix.
// Latency: one row update per memory word, so about (read latency + 2) cycles per row plus N write cycles per matrix.
// Backpressure: one read is outstanding at a time and the FSM stalls until i_mem_dout_vld; result writes are never stalled.
module gsim_solver_param #(
    parameter int N   = 16,
    parameter int DW  = 16,
    parameter int XW  = 32,
    parameter int IW  = 5,
    parameter int MW  = 5,
    parameter int AW  = 10,
    parameter int XAW = 9
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_module_en,
    input  logic [MW-1:0]     i_matrix_num,
    input  logic [IW-1:0]     i_iter_num,
    input  logic              i_tol_en,
    input  logic [XW-1:0]     i_tol,
    output logic              o_proc_done,
    output logic              o_busy,
    output logic              o_mem_rreq,
    output logic [AW-1:0]     o_mem_addr,
    input  logic              i_mem_dout_vld,
    input  logic [N*DW-1:0]   i_mem_dout,
    output logic              o_x_wen,
    output logic [XAW-1:0]    o_x_addr,
    output logic [XW-1:0]     o_x_data,
    output logic [IW-1:0]     o_iter_used
);
    localparam int PW  = XW + DW;          // product width
    localparam int SW  = PW + 5;           // accumulator width, headroom for 16 products
    localparam int IXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_B, S_ROW, S_WRITE, S_DONE} state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x [N];
    logic [DW-1:0]   r_b [N];
    logic [IXW-1:0]  r_i;
    logic [MW-1:0]   r_m;
    logic [MW-1:0]   r_mat_num;
    logic [IW-1:0]   r_iter_max;
    logic [IW-1:0]   r_sweep;
    logic [XW-1:0]   r_dmax;
    logic            r_pend;
    logic [AW-1:0]   r_base;
    logic [XAW-1:0]  r_xbase;

    logic [DW-1:0]   w_a [N];
    logic [PW-1:0]   w_prod [N];
    logic [SW-1:0]   w_sum;
    logic [SW-1:0]   w_bs;
    logic [SW-1:0]   w_sfull;
    logic [XW-1:0]   w_s;
    logic [PW-1:0]   w_p2;
    logic [PW-1:0]   w_sh;
    logic [XW-1:0]   w_xn;
    logic [XW:0]     w_d;
    logic [XW:0]     w_dabs;
    logic [XW-1:0]   w_delta;
    logic [XW-1:0]   w_dmax;
    logic [DW-1:0]   w_inv;
    logic [DW-1:0]   w_bi;
    logic [XW-1:0]   w_xold;
    logic [IW-1:0]   w_sweep_nxt;
    logic            w_stop;
    logic            w_rd_ok;

    // Clamp a wide signed value to the signed XW range.
    function automatic logic [XW-1:0] f_sat(input logic [SW-1:0] v);
        if ((&v[SW-1:XW-1]) || (~|v[SW-1:XW-1]))
            f_sat = v[XW-1:0];
        else if (v[SW-1])
            f_sat = {1'b1, {(XW-1){1'b0}}};
        else
            f_sat = {1'b0, {(XW-1){1'b1}}};
    endfunction

    // Split the memory word into fields and form a_ij * x_j for every column.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            w_a[j]    = i_mem_dout[DW*j +: DW];
            w_prod[j] = $signed({{XW{w_a[j][DW-1]}}, w_a[j]}) * $signed({{DW{r_x[j][XW-1]}}, r_x[j]});
        end
    end

    // Row update: residual, scale by 1/a_ii, and change against the old x_i.
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N; j++) begin
            if (IXW'(j) != r_i)
                w_sum = w_sum + {{(SW-PW){w_prod[j][PW-1]}}, w_prod[j]};
        end
        w_inv   = w_a[r_i];
        w_bi    = r_b[r_i];
        w_xold  = r_x[r_i];
        w_bs    = {{(SW-DW-16){w_bi[DW-1]}}, w_bi, 16'h0000};
        w_sfull = w_bs - w_sum;
        w_s     = f_sat(w_sfull);
        w_p2    = $signed({{DW{w_s[XW-1]}}, w_s}) * $signed({{XW{w_inv[DW-1]}}, w_inv});
        w_sh    = $signed(w_p2) >>> 14;
        w_xn    = f_sat({{(SW-PW){w_sh[PW-1]}}, w_sh});
        w_d     = {w_xn[XW-1], w_xn} - {w_xold[XW-1], w_xold};
        w_dabs  = w_d[XW] ? (~w_d + 1'b1) : w_d;
        w_delta = w_dabs[XW] ? {XW{1'b1}} : w_dabs[XW-1:0];
        w_dmax  = (w_delta > r_dmax) ? w_delta : r_dmax;
        w_sweep_nxt = r_sweep + IW'(1);
        w_stop  = (w_sweep_nxt == r_iter_max) || (i_tol_en && (w_dmax <= i_tol));
        w_rd_ok = r_pend && i_mem_dout_vld && !o_mem_rreq;
    end

    // Main FSM with registered outputs; dropping i_module_en aborts from any state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            for (int j = 0; j < N; j++) begin
                r_x[j] <= '0;
                r_b[j] <= '0;
            end
            r_i         <= '0;
            r_m         <= '0;
            r_mat_num   <= '0;
            r_iter_max  <= '0;
            r_sweep     <= '0;
            r_dmax      <= '0;
            r_pend      <= 1'b0;
            r_base      <= '0;
            r_xbase     <= '0;
            o_proc_done <= 1'b0;
            o_busy      <= 1'b0;
            o_mem_rreq  <= 1'b0;
            o_mem_addr  <= '0;
            o_x_wen     <= 1'b0;
            o_x_addr    <= '0;
            o_x_data    <= '0;
            o_iter_used <= '0;
        end else begin
            o_mem_rreq <= 1'b0;
            o_x_wen    <= 1'b0;
            if (!i_module_en && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_pend      <= 1'b0;
                o_busy      <= 1'b0;
                o_proc_done <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_module_en) begin
                            r_mat_num  <= i_matrix_num;
                            r_iter_max <= (i_iter_num == '0) ? IW'(1) : i_iter_num;
                            r_m        <= '0;
                            r_base     <= '0;
                            r_xbase    <= '0;
                            r_sweep    <= '0;
                            r_pend     <= 1'b0;
                            for (int j = 0; j < N; j++) r_x[j] <= '0;
                            if (i_matrix_num == '0) begin
                                r_state <= S_DONE;
                            end else begin
                                r_state <= S_LOAD_B;
                                o_busy  <= 1'b1;
                            end
                        end
                    end
                    S_LOAD_B: begin
                        if (!r_pend) begin
                            o_mem_rreq <= 1'b1;
                            o_mem_addr <= r_base;
                            r_pend     <= 1'b1;
                        end else if (w_rd_ok) begin
                            for (int j = 0; j < N; j++) r_b[j] <= w_a[j];
                            r_pend  <= 1'b0;
                            r_i     <= '0;
                            r_dmax  <= '0;
                            r_state <= S_ROW;
                        end
                    end
                    S_ROW: begin
                        if (!r_pend) begin
                            o_mem_rreq <= 1'b1;
                            o_mem_addr <= r_base + AW'(r_i) + AW'(1);
                            r_pend     <= 1'b1;
                        end else if (w_rd_ok) begin
                            r_x[r_i] <= w_xn;
                            r_pend   <= 1'b0;
                            if (r_i == IXW'(N-1)) begin
                                r_sweep <= w_sweep_nxt;
                                r_i     <= '0;
                                r_dmax  <= '0;
                                if (w_stop) r_state <= S_WRITE;
                            end else begin
                                r_i    <= r_i + IXW'(1);
                                r_dmax <= w_dmax;
                            end
                        end
                    end
                    S_WRITE: begin
                        o_x_wen  <= 1'b1;
                        o_x_addr <= r_xbase + XAW'(r_i);
                        o_x_data <= r_x[r_i];
                        if (r_i == '0) o_iter_used <= r_sweep;
                        if (r_i == IXW'(N-1)) begin
                            r_i <= '0;
                            if (r_m == r_mat_num - MW'(1)) begin
                                r_state <= S_DONE;
                                o_busy  <= 1'b0;
                            end else begin
                                r_m     <= r_m + MW'(1);
                                r_base  <= r_base + AW'(N+1);
                                r_xbase <= r_xbase + XAW'(N);
                                r_sweep <= '0;
                                r_state <= S_LOAD_B;
                            end
                        end else begin
                            r_i <= r_i + IXW'(1);
                        end
                    end
                    S_DONE: begin
                        o_proc_done <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gsim_solver_param.sv
// Directed bench for gsim_solver_param with N=4 and a stalling memory responder.
// Expected solutions are hand-computed for diagonal and lightly coupled systems.
// Results are captured from the write port and compared in order.
module tb_gsim_solver_param;
    localparam int N = 4, DW = 16, XW = 32, IW = 5, MW = 5, AW = 10, XAW = 9;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [MW-1:0]     mnum = '0;
    logic [IW-1:0]     inum = '0;
    logic              tol_en = 1'b0;
    logic [XW-1:0]     tol = '0;
    logic              proc_done, busy, rreq, xwen;
    logic [AW-1:0]     maddr;
    logic              vld = 1'b0;
    logic [N*DW-1:0]   dout = '0;
    logic [XAW-1:0]    xaddr;
    logic [XW-1:0]     xdata;
    logic [IW-1:0]     iter_used;

    always #5 clk = ~clk;

    gsim_solver_param #(.N(N), .DW(DW), .XW(XW), .IW(IW), .MW(MW), .AW(AW), .XAW(XAW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_module_en(en), .i_matrix_num(mnum),
        .i_iter_num(inum), .i_tol_en(tol_en), .i_tol(tol),
        .o_proc_done(proc_done), .o_busy(busy), .o_mem_rreq(rreq), .o_mem_addr(maddr),
        .i_mem_dout_vld(vld), .i_mem_dout(dout), .o_x_wen(xwen), .o_x_addr(xaddr),
        .o_x_data(xdata), .o_iter_used(iter_used)
    );

    logic [N*DW-1:0] mem [0:63];
    int n_tests = 0;
    int n_fail = 0;
    int rreq_cnt = 0;
    bit stall = 1'b0;
    logic [XW-1:0]  cap_d [$];
    logic [XAW-1:0] cap_a [$];
    logic [XW-1:0]  e [12];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] w4(input logic [15:0] f0, input logic [15:0] f1,
                                       input logic [15:0] f2, input logic [15:0] f3);
        return {f3, f2, f1, f0};
    endfunction

    task automatic set_diag(input int m, input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] b2, input logic [15:0] b3);
        logic [63:0] w;
        mem[m*5] = w4(b0, b1, b2, b3);
        for (int k = 0; k < 4; k++) begin
            w = '0;
            w[16*k +: 16] = 16'h1000;
            mem[m*5+1+k] = w;
        end
    endtask

    // Memory responder: answers each request after 1 + (0..7 when stalling) cycles.
    initial begin
        int cnt;
        bit pend;
        cnt = 0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            vld = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (rreq) begin
                pend = 1'b1;
                cnt = stall ? int'($urandom_range(7, 0)) : 0;
                dout = mem[maddr[5:0]];
                rreq_cnt++;
            end else if (pend) begin
                if (cnt == 0) begin
                    vld = 1'b1;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Result capture.
    initial begin
        forever begin
            @(negedge clk);
            if (xwen) begin
                cap_d.push_back(xdata);
                cap_a.push_back(xaddr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic run_job(input int mn, input int it, input bit te, input logic [31:0] tl);
        int c;
        cap_d.delete();
        cap_a.delete();
        rreq_cnt = 0;
        @(negedge clk);
        mnum = MW'(mn);
        inum = IW'(it);
        tol_en = te;
        tol = tl;
        en = 1'b1;
        @(negedge clk);
        if (mn != 0) check("busy_on_start", busy, 1);
        c = 0;
        while (!proc_done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("proc_done", proc_done, 1);
        check("busy_in_done", busy, 0);
    endtask

    task automatic end_job();
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("done_cleared", proc_done, 0);
    endtask

    task automatic check_res(input string tag, input int cnt);
        check({tag, "_nwr"}, cap_d.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            check({tag, "_addr"}, (i < cap_a.size()) ? 64'(cap_a[i]) : 64'hDEAD, i);
            check({tag, "_data"}, (i < cap_d.size()) ? 64'(cap_d[i]) : 64'hDEAD, e[i]);
        end
    endtask

    initial begin
        int c;
        int snap;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", proc_done, 0);
        check("rst_rreq", rreq, 0);
        check("rst_wen", xwen, 0);
        check("rst_outs", {maddr, xaddr, xdata, iter_used}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: diagonal system, one sweep
        set_diag(0, 16'd4, 16'd8, 16'hFFFC, 16'd0);
        e[0] = 32'h00010000; e[1] = 32'h00020000; e[2] = 32'hFFFF0000; e[3] = 32'h0;
        run_job(1, 1, 0, 0);
        check_res("t1", 4);
        check("t1_iter_used", iter_used, 1);
        check("t1_reads", rreq_cnt, 5);
        end_job();

        // iter_num=0 behaves as one sweep
        run_job(1, 0, 0, 0);
        check_res("t1z", 4);
        check("t1z_iter_used", iter_used, 1);
        check("t1z_reads", rreq_cnt, 5);
        end_job();

        // 2: coupled 2x2 block, Gauss-Seidel uses the fresh x0 for row 1
        set_diag(0, 16'd5, 16'd5, 16'd0, 16'd0);
        mem[1] = w4(16'h1000, 16'd1, 16'd0, 16'd0);
        mem[2] = w4(16'd1, 16'h1000, 16'd0, 16'd0);
        e[0] = 32'h00014000; e[1] = 32'h0000F000; e[2] = 32'h0; e[3] = 32'h0;
        run_job(1, 1, 0, 0);
        check_res("t2", 4);
        end_job();

        // 3: early stop on convergence with tol=0
        set_diag(0, 16'd4, 16'd8, 16'hFFFC, 16'd0);
        e[0] = 32'h00010000; e[1] = 32'h00020000; e[2] = 32'hFFFF0000; e[3] = 32'h0;
        run_job(1, 15, 1, 0);
        check_res("t3", 4);
        check("t3_iter_used", iter_used, 2);
        check("t3_row_reads", rreq_cnt - 1, 8);
        end_job();

        // 4: positive and negative saturation
        set_diag(0, 16'h7FFF, 16'd0, 16'd0, 16'd0);
        mem[1] = w4(16'h7FFF, 16'd0, 16'd0, 16'd0);
        e[0] = 32'h7FFFFFFF; e[1] = 32'h0; e[2] = 32'h0; e[3] = 32'h0;
        run_job(1, 1, 0, 0);
        check_res("t4p", 4);
        end_job();
        mem[0] = w4(16'h8000, 16'd0, 16'd0, 16'd0);
        e[0] = 32'h80000000;
        run_job(1, 1, 0, 0);
        check_res("t4n", 4);
        end_job();

        // 5: three matrices with random read stalls
        set_diag(0, 16'd4, 16'd8, 16'hFFFC, 16'd0);
        set_diag(1, 16'd1, 16'd2, 16'd3, 16'd4);
        set_diag(2, 16'hFFF8, 16'd12, 16'd100, 16'hFFFF);
        e[0] = 32'h00010000; e[1] = 32'h00020000; e[2]  = 32'hFFFF0000; e[3]  = 32'h0;
        e[4] = 32'h00004000; e[5] = 32'h00008000; e[6]  = 32'h0000C000; e[7]  = 32'h00010000;
        e[8] = 32'hFFFE0000; e[9] = 32'h00030000; e[10] = 32'h00190000; e[11] = 32'hFFFFC000;
        stall = 1'b1;
        run_job(3, 1, 0, 0);
        check_res("t5", 12);
        check("t5_iter_used", iter_used, 1);
        check("t5_reads", rreq_cnt, 15);
        end_job();

        // 6: abort during sweep 2, then a full rerun
        e[0] = 32'h00010000; e[1] = 32'h00020000; e[2] = 32'hFFFF0000; e[3] = 32'h0;
        stall = 1'b0;
        cap_d.delete();
        cap_a.delete();
        rreq_cnt = 0;
        @(negedge clk);
        mnum = 1; inum = 3; tol_en = 0; tol = 0; en = 1'b1;
        c = 0;
        while (rreq_cnt < 7 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("t6_reached_sweep2", rreq_cnt >= 7, 1);
        en = 1'b0;
        @(negedge clk);
        check("t6_busy_low", busy, 0);
        check("t6_rreq_low", rreq, 0);
        snap = rreq_cnt;
        repeat (15) @(negedge clk);
        check("t6_no_writes", cap_d.size(), 0);
        check("t6_no_reads", rreq_cnt, snap);
        stall = 1'b1;
        run_job(1, 3, 0, 0);
        check_res("t6r", 4);
        check("t6r_iter_used", iter_used, 3);
        check("t6r_reads", rreq_cnt, 13);
        end_job();
        stall = 1'b0;

        // matrix_num=0: straight to DONE with no reads
        run_job(0, 1, 0, 0);
        check("t7_reads", rreq_cnt, 0);
        check("t7_nwr", cap_d.size(), 0);
        end_job();

        // Reset in the middle of a run
        cap_d.delete();
        cap_a.delete();
        @(negedge clk);
        mnum = 1; inum = 15; tol_en = 0; en = 1'b1;
        repeat (10) @(negedge clk);
        check("t8_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t8_busy_rst", busy, 0);
        check("t8_rreq_rst", rreq, 0);
        check("t8_iter_used_rst", iter_used, 0);
        repeat (20) @(negedge clk);
        check("t8_no_writes", cap_d.size(), 0);
        en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t8_idle_after", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
